// File: rtl/priority_controller.sv
// Two-lift hall-call dispatcher: classifies each lift against the request and
// registers the winning lift one clock after a valid request is sampled.
module priority_controller #(
  parameter int FLOOR_W = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [FLOOR_W-1:0] curr_floor_L1,
  input  logic [FLOOR_W-1:0] dest_floor_L1,
  input  logic [FLOOR_W-1:0] curr_floor_L2,
  input  logic [FLOOR_W-1:0] dest_floor_L2,
  input  logic [FLOOR_W-1:0] req_floor,
  input  logic               req_direction,
  input  logic               req_valid,
  output logic [1:0]         selected_lift,
  output logic               sel_valid
);

  // Enum order doubles as the priority rank: lower value wins.
  typedef enum logic [1:0] {
    EN_ROUTE = 2'd0,
    IDLE     = 2'd1,
    OTHER    = 2'd2
  } lift_class_t;

  localparam logic [1:0] LIFT_NONE = 2'b00;
  localparam logic [1:0] LIFT_1    = 2'b01;
  localparam logic [1:0] LIFT_2    = 2'b10;

  function automatic lift_class_t classify(
    input logic [FLOOR_W-1:0] curr,
    input logic [FLOOR_W-1:0] dest,
    input logic [FLOOR_W-1:0] req,
    input logic               up
  );
    lift_class_t cls;
    cls = OTHER;
    if (dest == curr)
      cls = IDLE;
    else if (up && (dest > curr) && (curr <= req) && (req <= dest))
      cls = EN_ROUTE;
    else if (!up && (dest < curr) && (dest <= req) && (req <= curr))
      cls = EN_ROUTE;
    return cls;
  endfunction

  function automatic logic [FLOOR_W-1:0] abs_diff(
    input logic [FLOOR_W-1:0] a,
    input logic [FLOOR_W-1:0] b
  );
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  lift_class_t        cls_l1, cls_l2;
  logic [FLOOR_W-1:0] dist_l1, dist_l2, over_l1, over_l2;
  logic               pick_l2;
  logic [1:0]         lift_p0;

  always_comb begin
    cls_l1  = classify(curr_floor_L1, dest_floor_L1, req_floor, req_direction);
    cls_l2  = classify(curr_floor_L2, dest_floor_L2, req_floor, req_direction);
    dist_l1 = abs_diff(curr_floor_L1, req_floor);
    dist_l2 = abs_diff(curr_floor_L2, req_floor);
    over_l1 = abs_diff(dest_floor_L1, req_floor);
    over_l2 = abs_diff(dest_floor_L2, req_floor);

    // Lift 2 must strictly beat Lift 1; every full tie stays with Lift 1.
    pick_l2 = 1'b0;
    if (cls_l2 < cls_l1)
      pick_l2 = 1'b1;
    else if (cls_l2 == cls_l1) begin
      if (cls_l1 == EN_ROUTE)
        pick_l2 = (over_l2 < over_l1);
      else
        pick_l2 = (dist_l2 < dist_l1);
    end

    lift_p0 = pick_l2 ? LIFT_2 : LIFT_1;
  end

  // Decision register: output stage, cleared whenever no request is sampled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      selected_lift <= LIFT_NONE;
      sel_valid     <= 1'b0;
    end else if (req_valid) begin
      selected_lift <= lift_p0;
      sel_valid     <= 1'b1;
    end else begin
      selected_lift <= LIFT_NONE;
      sel_valid     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_priority_controller.sv
// Scoreboard bench for priority_controller: a reference model queues the
// expected decision at each sampling edge; a monitor pops and compares.
module tb_priority_controller;

  localparam int FW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [FW-1:0] c1 = '0, d1 = '0, c2 = '0, d2 = '0, rf = '0;
  logic          rd = 1'b0, rv = 1'b0;
  logic [1:0]    selected_lift;
  logic          sel_valid;

  int checks = 0;
  int failures = 0;

  // Optional literal expectation attached to the next sampled request.
  logic          lit_en = 1'b0;
  logic [1:0]    lit_val = 2'b00;
  string         lit_name = "";

  typedef struct {
    logic [1:0] lift;
    logic       vld;
    logic       has_lit;
    logic [1:0] lit;
    string      name;
  } exp_t;

  exp_t q[$];

  priority_controller #(.FLOOR_W(FW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .curr_floor_L1 (c1),
    .dest_floor_L1 (d1),
    .curr_floor_L2 (c2),
    .dest_floor_L2 (d2),
    .req_floor     (rf),
    .req_direction (rd),
    .req_valid     (rv),
    .selected_lift (selected_lift),
    .sel_valid     (sel_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // 0 = en route, 1 = idle, 2 = other
  function automatic int rank_of(input int c, input int d, input int f, input bit up);
    int lo, hi;
    if (c == d) return 1;
    lo = (c < d) ? c : d;
    hi = (c < d) ? d : c;
    if (((d > c) == up) && f >= lo && f <= hi) return 0;
    return 2;
  endfunction

  function automatic int iabs(input int x);
    return (x < 0) ? -x : x;
  endfunction

  function automatic logic [1:0] model(input int a1, input int b1, input int a2,
                                       input int b2, input int f, input bit up);
    int r1, r2, k1, k2;
    r1 = rank_of(a1, b1, f, up);
    r2 = rank_of(a2, b2, f, up);
    if (r1 == 0 && r2 == 0) begin
      k1 = iabs(b1 - f);
      k2 = iabs(b2 - f);
    end else begin
      k1 = r1 * 16 + iabs(a1 - f);
      k2 = r2 * 16 + iabs(a2 - f);
    end
    return (k1 <= k2) ? 2'b01 : 2'b10;
  endfunction

  // Reference model: one expected entry per sampling edge out of reset.
  always @(posedge clk) begin
    exp_t e;
    if (rst_n) begin
      e.vld     = rv;
      e.lift    = rv ? model(int'(c1), int'(d1), int'(c2), int'(d2), int'(rf), rd) : 2'b00;
      e.has_lit = rv && lit_en;
      e.lit     = lit_val;
      e.name    = lit_name;
      q.push_back(e);
    end
  end

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      q.delete();
      check("reset_lift", int'(selected_lift), 0);
      check("reset_vld", int'(sel_valid), 0);
    end else if (q.size() > 0) begin
      e = q.pop_front();
      check("lift", int'(selected_lift), int'(e.lift));
      check("sel_valid", int'(sel_valid), int'(e.vld));
      if (e.has_lit) check(e.name, int'(selected_lift), int'(e.lit));
    end
  end

  task automatic req(input int a1, input int b1, input int a2, input int b2,
                     input int f, input bit up, input bit use_lit,
                     input logic [1:0] lit, input string name);
    @(negedge clk);
    c1 = FW'(a1); d1 = FW'(b1); c2 = FW'(a2); d2 = FW'(b2);
    rf = FW'(f); rd = up; rv = 1'b1;
    lit_en = use_lit; lit_val = lit; lit_name = name;
  endtask

  task automatic gap();
    @(negedge clk);
    rv = 1'b0; lit_en = 1'b0;
    c1 = FW'($urandom); d1 = FW'($urandom); c2 = FW'($urandom);
    d2 = FW'($urandom); rf = FW'($urandom); rd = 1'($urandom);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    req(2, 5, 3, 3, 4, 1, 1, 2'b01, "enroute_beats_idle");
    req(5, 1, 2, 6, 4, 1, 1, 2'b10, "opposite_vs_enroute");
    req(5, 1, 1, 5, 4, 1, 1, 2'b10, "opposite_vs_enroute_b");
    req(2, 6, 1, 5, 3, 1, 1, 2'b10, "smaller_overshoot_up");
    req(6, 1, 2, 6, 4, 0, 1, 2'b01, "enroute_down");
    req(2, 2, 5, 5, 3, 1, 1, 2'b01, "idle_nearer_l1");
    req(2, 2, 3, 3, 4, 0, 1, 2'b10, "idle_nearer_l2");
    gap();
    req(2, 2, 4, 4, 3, 1, 1, 2'b01, "idle_tie_l1");
    req(0, 7, 7, 0, 0, 1, 1, 2'b01, "floor0_up");
    req(0, 7, 7, 0, 7, 0, 1, 2'b10, "top_down");
    req(4, 6, 3, 3, 4, 1, 1, 2'b01, "at_floor_enroute");
    gap();
    gap();

    // Mid-stream reset with a valid request still asserted.
    req(1, 6, 6, 1, 3, 1, 0, 2'b00, "");
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_lift", int'(selected_lift), 0);
    check("async_reset_vld", int'(sel_valid), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    req(2, 5, 3, 3, 4, 1, 1, 2'b01, "first_after_reset");

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 4) == 0) gap();
      else begin
        int a1, b1, a2, b2;
        a1 = $urandom_range(0, 7);
        a2 = $urandom_range(0, 7);
        b1 = ($urandom_range(0, 3) == 0) ? a1 : $urandom_range(0, 7);
        b2 = ($urandom_range(0, 3) == 0) ? a2 : $urandom_range(0, 7);
        req(a1, b1, a2, b2, $urandom_range(0, 7), 1'($urandom), 0, 2'b00, "");
      end
    end

    gap();
    repeat (3) @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/priority_controller.md
Name: priority_controller

Overview:
Dispatch arbiter for a two-lift elevator system. On each valid hall request (floor plus up/down direction), it chooses which lift serves the call from each lift's current and destination floors. The choice is registered and presented one clock later to the lift sequencers. The block is purely a decision stage: it never moves lifts and never queues requests.

Parameters:
FLOOR_W, 3, width of every floor field (floors 0 .. 2^FLOOR_W-1).

Ports:
clk  in  1  system clock, rising-edge active
rst_n  in  1  asynchronous active-low reset
curr_floor_L1  in  FLOOR_W  Lift 1 current floor
dest_floor_L1  in  FLOOR_W  Lift 1 destination floor
curr_floor_L2  in  FLOOR_W  Lift 2 current floor
dest_floor_L2  in  FLOOR_W  Lift 2 destination floor
req_floor  in  FLOOR_W  requested floor
req_direction  in  1  requested direction, 1 = up, 0 = down
req_valid  in  1  request strobe, sampled every rising clk edge
selected_lift  out  2  00 = none, 01 = Lift 1, 10 = Lift 2; 11 never driven
sel_valid  out  1  high for one cycle with each new decision

Behaviour:
- Reset: while rst_n = 0, selected_lift = 00 and sel_valid = 0, asynchronously and immediately. This also applies mid-operation: any pending decision is discarded.
- Latency: inputs are sampled on edge N while req_valid = 1. The decision is on selected_lift and sel_valid = 1 after edge N.
- If req_valid = 0 at an edge, selected_lift <= 00 and sel_valid <= 0.
- Back-to-back valid cycles each yield an independent decision. There is no history and no busy tracking.
- Per-lift state, derived combinationally:
  - idle: dest == curr.
  - up: dest > curr.
  - down: dest < curr.
- Per-lift class:
  - EN_ROUTE (rank 0): the lift is moving in req_direction and req_floor lies on its path, inclusive of both ends. For up: curr <= req <= dest. For down: dest <= req <= curr.
  - IDLE (rank 1): state idle; direction is ignored.
  - OTHER (rank 2): every remaining case, i.e. moving the opposite way or the request is off its path.
- dist = |curr - req_floor| and over = |dest - req_floor|, both unsigned FLOOR_W bits with no wrap.
- Selection order:
  1. The lower rank wins.
  2. If ranks are equal and both are EN_ROUTE, the smaller over wins (less travel beyond the call).
  3. If ranks are equal otherwise, the smaller dist wins.
  4. Any remaining tie goes to Lift 1.
- A valid request always selects exactly one lift (01 or 10). 00 appears only when there is no valid request or during reset.
- Boundary cases:
  - A lift already at req_floor: dist = 0, and it is EN_ROUTE if it is moving in the requested direction.
  - Requests at floor 0 or the top floor are handled like any other floor.
  - Inputs changing while req_valid = 0 have no effect.

Test Plan:
- Reset asserted mid-stream with req_valid = 1 -> selected_lift = 00 and sel_valid = 0 immediately; the first decision arrives one edge after rst_n rises.
- L1 2->5, L2 3->3, req 4 up -> 01 (en route beats a nearer idle lift).
- L1 5->1, L2 2->6, req 4 up -> 10. Second stimulus: L1 5->1, L2 1->5, req 4 up -> 10.
- L1 2->6, L2 1->5, req 3 up -> 10 (both en route, smaller overshoot). Second stimulus: L1 6->1, L2 2->6, req 4 down -> 01.
- Both idle: L1 2, L2 5, req 3 -> 01. L1 2, L2 3, req 4 -> 10. Equal distance (L1 2, L2 4, req 3) -> 01.
- req_valid low for one cycle between two requests -> 00 with sel_valid = 0 in that cycle; each valid cycle pulses sel_valid.
